// File: rtl/psum_accum_pkg.sv
// ============================================================================
// Module      : psum_accum_pkg
// Description : Shared mode codes, FSM encoding and rescale constant for the
//               partial-sum accumulation controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package psum_accum_pkg;

   localparam logic [1:0] MODE_INT8     = 2'd0;
   localparam logic [1:0] MODE_INT4     = 2'd1;
   localparam logic [1:0] MODE_INT4_VSQ = 2'd2;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ACCUM = 2'd1;
   localparam logic [1:0] ST_OUT   = 2'd2;

   // The mac defers the VSQ scale by this many bits; requant restores it.
   localparam int VSQ_RESCALE = 8;

endpackage : psum_accum_pkg

`default_nettype wire

// File: rtl/psum_accum_requant_int8.sv
// ============================================================================
// Module      : requant_int8
// Description : Combinational requantizer: VSQ rescale, round-half-up
//               arithmetic right shift, saturation to a signed OUT_W result.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module requant_int8
   import psum_accum_pkg::*;
#(
   parameter int ACC_W = 24,
   parameter int OUT_W = 8
) (
   input  logic [ACC_W-1:0] i_value,
   input  logic [1:0]       i_mode,
   input  logic [4:0]       i_shift,
   output logic [OUT_W-1:0] o_data
);

   localparam logic signed [31:0] c_sat_max = (32'sd1 <<< (OUT_W - 1)) - 32'sd1;
   localparam logic signed [31:0] c_sat_min = -(32'sd1 <<< (OUT_W - 1));

   logic signed [31:0] w_x;
   logic signed [31:0] w_r;

   // All arithmetic is 32-bit signed; ACC_W + VSQ_RESCALE must fit in 32.
   always_comb begin
      w_x = 32'($signed(i_value));
      if (i_mode == MODE_INT4_VSQ) begin
         w_x = w_x <<< VSQ_RESCALE;
      end
      w_r = w_x;
      if (i_shift != 5'd0) begin
         w_r = (w_x + (32'sd1 <<< (i_shift - 5'd1))) >>> i_shift;
      end
      if (w_r > c_sat_max) begin
         o_data = c_sat_max[OUT_W-1:0];
      end else if (w_r < c_sat_min) begin
         o_data = c_sat_min[OUT_W-1:0];
      end else begin
         o_data = w_r[OUT_W-1:0];
      end
   end

endmodule : requant_int8

`default_nettype wire

// File: rtl/psum_accum.sv
// ============================================================================
// Module      : psum_accum
// Description : Partial-sum owner for the mac stage: counts tile beats,
//               requantizes the final sum and hands it off via valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module psum_accum
   import psum_accum_pkg::*;
#(
   parameter int ACC_W = 24,
   parameter int OUT_W = 8
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_start,
   input  logic [1:0]       i_mode,
   input  logic [7:0]       i_num_tiles,
   input  logic [4:0]       i_out_shift,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [ACC_W-1:0] i_result,
   output logic [ACC_W-1:0] o_psum,
   output logic [1:0]       o_mode,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [OUT_W-1:0] o_data,
   output logic [ACC_W-1:0] o_acc,
   output logic             o_busy
);

   logic [1:0]       r_state;
   logic [1:0]       r_mode;
   logic [7:0]       r_last_idx;
   logic [4:0]       r_shift;
   logic [7:0]       r_cnt;
   logic [ACC_W-1:0] r_psum;
   logic [OUT_W-1:0] r_data;
   logic [ACC_W-1:0] r_acc;

   logic [OUT_W-1:0] w_requant;
   logic             w_last_beat;

   requant_int8 #(
      .ACC_W (ACC_W),
      .OUT_W (OUT_W)
   ) u_requant (
      .i_value (i_result),
      .i_mode  (r_mode),
      .i_shift (r_shift),
      .o_data  (w_requant)
   );

   assign w_last_beat = (r_cnt == r_last_idx);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= ST_IDLE;
         r_mode     <= 2'd0;
         r_last_idx <= 8'd0;
         r_shift    <= 5'd0;
         r_cnt      <= 8'd0;
         r_psum     <= '0;
         r_data     <= '0;
         r_acc      <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (i_start) begin
                  r_mode     <= i_mode;
                  // A tile count of 0 behaves as a single beat.
                  r_last_idx <= (i_num_tiles == 8'd0) ? 8'd0 : i_num_tiles - 8'd1;
                  r_shift    <= i_out_shift;
                  r_cnt      <= 8'd0;
                  r_psum     <= '0;
                  r_state    <= ST_ACCUM;
               end
            end
            ST_ACCUM: begin
               if (i_valid) begin
                  r_psum <= i_result;
                  r_cnt  <= r_cnt + 8'd1;
                  if (w_last_beat) begin
                     r_acc   <= i_result;
                     r_data  <= w_requant;
                     r_state <= ST_OUT;
                  end
               end
            end
            ST_OUT: begin
               if (i_ready) begin
                  r_state <= ST_IDLE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign o_ready = (r_state == ST_ACCUM);
   assign o_valid = (r_state == ST_OUT);
   assign o_busy  = (r_state != ST_IDLE);
   assign o_psum  = r_psum;
   assign o_mode  = r_mode;
   assign o_data  = r_data;
   assign o_acc   = r_acc;

endmodule : psum_accum

`default_nettype wire

// File: doc/psum_accum.md
# psum_accum

Accumulation controller sitting directly downstream of the `mac` dot-product stage. It owns the partial-sum register that feeds the mac's psum input. It counts tile beats for one output element and closes the deferred VSQ `<<8` rescale. It requantizes the final sum to INT8 and hands it off over a valid/ready port.

## Interface
Parameters:
- `ACC_W`, 24: partial-sum width; matches the mac psum/result width.
- `OUT_W`, 8: requantized output width.

Ports:
- `i_clk` in 1: clock. One clock domain only.
- `i_rst_n` in 1: reset, asynchronous, active-low.
- `i_start` in 1: begins one output element. Sampled only in IDLE.
- `i_mode` in 2: `INT8`/`INT4`/`INT4_VSQ` from `define.v`. Latched on start.
- `i_num_tiles` in 8: beats per element. A value of 0 is treated as 1. Latched on start.
- `i_out_shift` in 5: requant arithmetic right shift. Latched on start.
- `i_valid` in 1: mac result for the current tile is valid.
- `o_ready` out 1: the block accepts a mac result.
- `i_result` in ACC_W: mac result, which is psum plus dot product.
- `o_psum` out ACC_W: registered partial sum, driven to the mac psum input.
- `o_mode` out 2: latched mode, driven to the mac mode input.
- `o_valid` out 1: requantized result is available.
- `i_ready` in 1: downstream accepts the result.
- `o_data` out OUT_W: requantized signed result.
- `o_acc` out ACC_W: raw final partial sum, for debug and bypass.
- `o_busy` out 1: high in any state other than IDLE.

## Operation
FSM states: IDLE, ACCUM, OUT.
- **IDLE**
  - `o_ready=0`, `o_valid=0`.
  - On `i_start`: latch mode, tile count and shift; clear psum and the beat counter; go to ACCUM.
- **ACCUM**
  - `o_ready=1`.
  - On each `i_valid`: `psum <= i_result` and `cnt++`.
  - On the beat where `cnt == num_tiles-1`: register `o_acc <= i_result` and `o_data <= requant(i_result)`, then go to OUT.
- **OUT**
  - `o_valid=1`, and `o_data`/`o_acc` are held stable.
  - On `i_ready`: go to IDLE.
- `i_start` is ignored outside IDLE.
- `i_valid` is ignored outside ACCUM.

Requant, computed at 32-bit signed:
1. `x = sext(i_result)`. In INT4_VSQ mode, `x <<= 8`, which restores the mac's rounded scale product.
2. If `shift > 0`, `x = (x + (1 << (shift-1))) >>> shift`. This is round-half-up toward +inf.
3. Saturate `x` to [-128, 127].

INT8 and INT4 skip step 1.

No saturation is applied to the accumulation itself. The mac owns overflow behaviour for `i_result`.

## Timing
- Reset values: state IDLE; `psum`, `cnt`, `o_data`, `o_acc`, latched config all 0. This gives `o_ready=0`, `o_valid=0`, `o_busy=0`, `o_psum=0`, `o_mode=0`.
- **Start:** `i_start` at edge E gives `o_ready=1` after E. `o_psum=0` is valid for the first beat.
- **Beats:** a beat accepted at edge N updates `o_psum` after N, so the mac sees the new psum one cycle later. Beats may be back-to-back or have gaps.
- **Last beat:** the final beat at edge N gives `o_valid=1` after N. This is a 1-cycle latency.
- **Handoff:** with `i_ready=1` already high, the handshake completes at edge N+1 and the block returns to IDLE. The next `i_start` is accepted at edge N+2 at the earliest.
- **Backpressure:** `o_valid` stays high with stable data until `i_ready`.
- **Asynchronous reset** mid-element drops everything immediately to reset values. No partial output is produced.

## Structure
- Mode codes stay in `define.v`.
- Add to the same include: the state encoding constants `ST_IDLE=0`, `ST_ACCUM=1`, `ST_OUT=2`, and `VSQ_RESCALE=8`.
- One combinational sub-module, `requant_int8` (in: value, mode, shift; out: 8-bit), so it can be unit-tested standalone.

## Test plan
- **INT8, 3 tiles, shift 4:** results 100, 250, 1000 → `o_psum` sequence 0, 100, 250; `o_acc=1000`; `o_data=63`.
- **INT4_VSQ, 1 tile, shift 4:** result -3 → x=-768, then (-760)>>>4 → `o_data=-48`.
- **Saturation, INT8, shift 0:** result 24'h7FFFFF → 127. Result -200 → -128.
- **Backpressure:** hold `i_ready=0` for 5 cycles in OUT → `o_valid` and `o_data` stable; `i_start` and `i_valid` pulses are ignored; the element completes on the first `i_ready`.
- **`num_tiles=0` with gapped `i_valid`:** finishes after exactly one beat. A 4-tile run with 2-cycle gaps counts only valid beats.
- **Reset mid-ACCUM:** after 2 of 4 beats, assert `i_rst_n=0` → all outputs return to reset values asynchronously. A fresh start then accumulates from 0.
